// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the sequencer: phase codes seen by the control unit,
// the default instruction width and the sequencer's internal state type.
package cpu_sequencer_pkg;

    localparam logic [1:0] ST_LOAD    = 2'b00;
    localparam logic [1:0] ST_FETCH   = 2'b01;
    localparam logic [1:0] ST_DECODE  = 2'b10;
    localparam logic [1:0] ST_EXECUTE = 2'b11;

    localparam int CPU_INSTR_W = 12;

    typedef enum logic [2:0] {
        S_LOAD,
        S_HALT,
        S_FETCH,
        S_DECODE,
        S_EXEC
    } seq_state_t;

endpackage

// File: rtl/cpu_sequencer_rise_detect.sv
// Rising-edge detector: one flop of history, pulse while din is high and was low last cycle.
module cpu_sequencer_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) din_q <= 1'b0;
        else     din_q <= din;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/cpu_sequencer.sv
// CPU phase sequencer: streams a program image into memory, then runs
// FETCH/DECODE/EXECUTE with halt, single-step and free-run control.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int PM_DEPTH = 256,
    parameter int PM_AW    = 8,
    parameter int INSTR_W  = CPU_INSTR_W,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic [PM_AW-1:0]   pm_waddr,
    output logic [INSTR_W-1:0] pm_wdata,
    input  logic               run,
    input  logic               step,
    input  logic               reload,
    output logic [1:0]         state,
    output logic               cu_valid,
    output logic               halted,
    output logic               load_done,
    output logic               load_overflow,
    output logic [CNT_W-1:0]   instr_count
);

    seq_state_t       fsm, fsm_nxt;
    logic [PM_AW-1:0] addr;
    logic             step_mode;
    logic             step_rise;
    logic             accept;
    logic             last_addr;

    cpu_sequencer_rise_detect u_step_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (step),
        .rise (step_rise)
    );

    assign accept    = ld_valid & ld_ready;
    assign last_addr = (addr == PM_AW'(PM_DEPTH - 1));
    assign pm_waddr  = addr;
    assign pm_wdata  = ld_data;

    // State register plus the counters/flags that move with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm           <= S_LOAD;
            addr          <= '0;
            load_done     <= 1'b0;
            load_overflow <= 1'b0;
            instr_count   <= '0;
            step_mode     <= 1'b0;
        end else begin
            fsm <= fsm_nxt;
            case (fsm)
                S_LOAD: begin
                    if (accept) begin
                        addr <= addr + 1'b1;
                        if (ld_last || last_addr) begin
                            load_done     <= 1'b1;
                            load_overflow <= ~ld_last;
                        end
                    end
                end
                S_HALT: begin
                    if (reload) begin
                        addr          <= '0;
                        load_done     <= 1'b0;
                        load_overflow <= 1'b0;
                    end else if (run) begin
                        step_mode <= 1'b0;
                    end else if (step_rise) begin
                        step_mode <= 1'b1;
                    end
                end
                S_EXEC:  instr_count <= instr_count + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            S_LOAD:   if (accept && (ld_last || last_addr)) fsm_nxt = S_HALT;
            S_HALT: begin
                if (reload)                fsm_nxt = S_LOAD;
                else if (run || step_rise) fsm_nxt = S_FETCH;
            end
            S_FETCH:  fsm_nxt = S_DECODE;
            S_DECODE: fsm_nxt = S_EXEC;
            S_EXEC:   fsm_nxt = (step_mode || !run) ? S_HALT : S_FETCH;
            default:  fsm_nxt = S_LOAD;
        endcase
    end

    // cu_valid is also gated by rst so an asserted reset never enables the control unit
    always_comb begin
        state    = ST_LOAD;
        cu_valid = 1'b0;
        ld_ready = 1'b0;
        halted   = 1'b0;
        case (fsm)
            S_LOAD: begin
                ld_ready = 1'b1;
                cu_valid = ld_valid & ~rst;
            end
            S_HALT:   halted = 1'b1;
            S_FETCH:  begin state = ST_FETCH;   cu_valid = 1'b1; end
            S_DECODE: begin state = ST_DECODE;  cu_valid = 1'b1; end
            S_EXEC:   begin state = ST_EXECUTE; cu_valid = 1'b1; end
            default:  ;
        endcase
    end

endmodule
